// File: rtl/rr_arbiter_4_pkg.sv
// Shared types, sizes and the rotating priority pick for the 4-way round-robin arbiter.
// Contents: arb_state_t (IDLE/GRANT), N_REQ, IDX_W, rotate_pick().
package arb_pkg;

   localparam int unsigned N_REQ = 4;
   localparam int unsigned IDX_W = 2;

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } arb_state_t;

   // First set request bit found scanning ptr, ptr+1, ... with 2-bit wrap; one-hot result.
   function automatic logic [N_REQ-1:0] rotate_pick(input logic [N_REQ-1:0] req,
                                                    input logic [IDX_W-1:0] ptr);
      logic [IDX_W-1:0] idx;
      logic             found;
      rotate_pick = '0;
      found       = 1'b0;
      for (int i = 0; i < int'(N_REQ); i++) begin
         idx = ptr + IDX_W'(i);
         if (!found && req[idx]) begin
            rotate_pick[idx] = 1'b1;
            found            = 1'b1;
         end
      end
   endfunction

endpackage

// File: rtl/rr_arbiter_4_if.sv
// Request/grant bundle between the requesters and rr_arbiter_4.
//   req     : level request per requester
//   rel     : release strobe per requester (only the owner's bit matters)
//   gnt     : one-hot grant
//   gnt_idx : binary index of the owner
//   gnt_vld : a grant is active
//   timeout : one-cycle pulse on a forced release
// master = requester side, slave = arbiter side.
interface rr_arbiter_4_if;
   import arb_pkg::*;

   logic [N_REQ-1:0] req;
   logic [N_REQ-1:0] rel;
   logic [N_REQ-1:0] gnt;
   logic [IDX_W-1:0] gnt_idx;
   logic             gnt_vld;
   logic             timeout;

   modport master (
      output req, rel,
      input  gnt, gnt_idx, gnt_vld, timeout
   );

   modport slave (
      input  req, rel,
      output gnt, gnt_idx, gnt_vld, timeout
   );

endinterface

// File: rtl/rr_arbiter_4_onehot4_to_bin.sv
// Combinational one-hot to 2-bit binary decode of the arbitration winner.
//   oh  : one-hot input (non one-hot patterns decode to 0)
//   idx : binary index
module onehot4_to_bin
   import arb_pkg::*;
(
   input  logic [N_REQ-1:0] oh,
   output logic [IDX_W-1:0] idx
);

   always_comb begin : decode
      idx = '0;
      case (oh)
         4'b0001: idx = 2'd0;
         4'b0010: idx = 2'd1;
         4'b0100: idx = 2'd2;
         4'b1000: idx = 2'd3;
         default: idx = 2'd0;
      endcase
   end

endmodule

// File: rtl/rr_arbiter_4.sv
// Four-requester round-robin arbiter for a single-owner resource.
// A grant is held until the owner pulses rel or drops req; at least one idle cycle
// separates any two grants, and the priority pointer moves past the last owner.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   arb   : rr_arbiter_4_if.slave (req, rel in; gnt, gnt_idx, gnt_vld, timeout out)
// Parameters: MAX_HOLD (grant cycle limit), HOLD_W (hold counter width, 2**HOLD_W > MAX_HOLD).
// Optional macro ARB_TIMEOUT_EN: builds the hold counter and forced release with timeout
// pulse; when undefined a grant is held indefinitely and timeout is tied 0.
module rr_arbiter_4
   import arb_pkg::*;
#(
   parameter int unsigned MAX_HOLD = 16,
   parameter int unsigned HOLD_W   = 5
) (
   input  logic           clk,
   input  logic           rst_n,
   rr_arbiter_4_if.slave  arb
);

   // Elaboration-time guard: the counter must be able to reach MAX_HOLD-1.
   if ((2 ** HOLD_W) <= MAX_HOLD) begin : g_bad_cfg
      $error("rr_arbiter_4: HOLD_W too narrow for MAX_HOLD");
   end

   arb_state_t       state_q, state_d;
   logic [N_REQ-1:0] gnt_q, gnt_d;
   logic [IDX_W-1:0] gnt_idx_q, gnt_idx_d;
   logic             gnt_vld_q, gnt_vld_d;
   logic [IDX_W-1:0] ptr_q, ptr_d;

   logic [N_REQ-1:0] win_oh;
   logic [IDX_W-1:0] win_idx;
   logic             release_c;
   logic             force_c;

   // Rotating-priority winner and its binary index.
   assign win_oh = rotate_pick(arb.req, ptr_q);

   onehot4_to_bin u_dec (
      .oh  (win_oh),
      .idx (win_idx)
   );

   // Owner gives the resource back by strobing rel or by dropping its request.
   assign release_c = arb.rel[gnt_idx_q] | ~arb.req[gnt_idx_q];

`ifdef ARB_TIMEOUT_EN
   logic [HOLD_W-1:0] hold_q, hold_d;
   logic              timeout_q, timeout_d;

   // Limit reached with no voluntary release in the same cycle.
   assign force_c = (hold_q == HOLD_W'(MAX_HOLD - 1)) & ~release_c;
`else
   assign force_c = 1'b0;
`endif

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin : state_reg
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // Next-state logic.
   always_comb begin : next_state
      state_d = state_q;
      case (state_q)
         IDLE:    if (|arb.req)             state_d = GRANT;
         GRANT:   if (release_c || force_c) state_d = IDLE;
         default:                           state_d = IDLE;
      endcase
   end

   // Next values of the output, pointer and hold registers.
   always_comb begin : output_logic
      gnt_d     = gnt_q;
      gnt_idx_d = gnt_idx_q;
      ptr_d     = ptr_q;
      case (state_q)
         IDLE: begin
            if (|arb.req) begin
               gnt_d     = win_oh;
               gnt_idx_d = win_idx;
            end
         end
         GRANT: begin
            if (release_c || force_c) begin
               gnt_d = '0;
               ptr_d = gnt_idx_q + IDX_W'(1);
            end
         end
         default: begin
            gnt_d = '0;
         end
      endcase
      gnt_vld_d = |gnt_d;
`ifdef ARB_TIMEOUT_EN
      hold_d    = '0;
      timeout_d = 1'b0;
      if (state_q == GRANT) begin
         timeout_d = force_c;
         if (!(release_c || force_c)) hold_d = hold_q + HOLD_W'(1);
      end
`endif
   end

   // Output and bookkeeping registers.
   always_ff @(posedge clk or negedge rst_n) begin : out_reg
      if (!rst_n) begin
         gnt_q     <= '0;
         gnt_idx_q <= '0;
         gnt_vld_q <= 1'b0;
         ptr_q     <= '0;
      end else begin
         gnt_q     <= gnt_d;
         gnt_idx_q <= gnt_idx_d;
         gnt_vld_q <= gnt_vld_d;
         ptr_q     <= ptr_d;
      end
   end

`ifdef ARB_TIMEOUT_EN
   // Hold counter and timeout pulse.
   always_ff @(posedge clk or negedge rst_n) begin : hold_reg
      if (!rst_n) begin
         hold_q    <= '0;
         timeout_q <= 1'b0;
      end else begin
         hold_q    <= hold_d;
         timeout_q <= timeout_d;
      end
   end

   assign arb.timeout = timeout_q;
`else
   assign arb.timeout = 1'b0;
`endif

   assign arb.gnt     = gnt_q;
   assign arb.gnt_idx = gnt_idx_q;
   assign arb.gnt_vld = gnt_vld_q;

endmodule

// File: tb/tb_rr_arbiter_4.sv
// Directed self-checking bench for rr_arbiter_4 (timeout scenario follows ARB_TIMEOUT_EN).
module tb_rr_arbiter_4;
   import arb_pkg::*;

   logic clk;
   logic rst_n;
   int   n_tests;
   int   n_fail;

   rr_arbiter_4_if arb_if ();

   rr_arbiter_4 #(
      .MAX_HOLD (16),
      .HOLD_W   (5)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .arb   (arb_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one clock; outputs are then sampled 1 time unit after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n      = 1'b0;
      arb_if.req = 4'b1111;
      arb_if.rel = 4'b0000;
      tick();
      tick();
      n_tests++;
      if (arb_if.gnt !== 4'b0000) begin
         n_fail++; $display("FAIL reset_gnt got %b exp 0000", arb_if.gnt);
      end
      n_tests++;
      if (arb_if.gnt_vld !== 1'b0) begin
         n_fail++; $display("FAIL reset_vld got %b exp 0", arb_if.gnt_vld);
      end
      n_tests++;
      if (arb_if.gnt_idx !== 2'd0) begin
         n_fail++; $display("FAIL reset_idx got %0d exp 0", arb_if.gnt_idx);
      end
      n_tests++;
      if (arb_if.timeout !== 1'b0) begin
         n_fail++; $display("FAIL reset_timeout got %b exp 0", arb_if.timeout);
      end
      rst_n = 1'b1;
      tick();
      n_tests++;
      if (arb_if.gnt !== 4'b0001 || arb_if.gnt_idx !== 2'd0 || arb_if.gnt_vld !== 1'b1) begin
         n_fail++;
         $display("FAIL first_grant got gnt=%b idx=%0d vld=%b exp 0001/0/1",
                  arb_if.gnt, arb_if.gnt_idx, arb_if.gnt_vld);
      end
   endtask

   task automatic test_rotation();
      logic [3:0] exp_seq [9];
      logic [1:0] exp_idx [9];
      exp_seq = '{4'b0001, 4'b0000, 4'b0010, 4'b0000, 4'b0100,
                  4'b0000, 4'b1000, 4'b0000, 4'b0001};
      exp_idx = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd3, 2'd3, 2'd0};
      for (int k = 0; k < 9; k++) begin
         n_tests++;
         if (arb_if.gnt !== exp_seq[k] || arb_if.gnt_vld !== (|exp_seq[k])
             || arb_if.gnt_idx !== exp_idx[k]) begin
            n_fail++;
            $display("FAIL rotation_step%0d got gnt=%b vld=%b idx=%0d exp %b/%b/%0d", k,
                     arb_if.gnt, arb_if.gnt_vld, arb_if.gnt_idx,
                     exp_seq[k], |exp_seq[k], exp_idx[k]);
         end
         arb_if.rel = exp_seq[k];
         tick();
      end
      // Last release leaves ptr=1, now idle.
      arb_if.rel = 4'b0000;
      arb_if.req = 4'b0000;
      tick();
      n_tests++;
      if (arb_if.gnt !== 4'b0000) begin
         n_fail++; $display("FAIL rotation_idle got %b exp 0000", arb_if.gnt);
      end
   endtask

   task automatic test_skip_wrap();
      arb_if.req = 4'b0100;
      tick();
      n_tests++;
      if (arb_if.gnt !== 4'b0100 || arb_if.gnt_idx !== 2'd2) begin
         n_fail++;
         $display("FAIL skip_grant2 got gnt=%b idx=%0d exp 0100/2", arb_if.gnt, arb_if.gnt_idx);
      end
      arb_if.rel = 4'b0100;
      tick();
      arb_if.rel = 4'b0000;
      arb_if.req = 4'b0011;
      tick();
      n_tests++;
      if (arb_if.gnt !== 4'b0001 || arb_if.gnt_idx !== 2'd0) begin
         n_fail++;
         $display("FAIL wrap_grant0 got gnt=%b idx=%0d exp 0001/0", arb_if.gnt, arb_if.gnt_idx);
      end
      arb_if.rel = 4'b0001;
      tick();
      arb_if.rel = 4'b0000;
      tick();
      n_tests++;
      if (arb_if.gnt !== 4'b0010 || arb_if.gnt_idx !== 2'd1) begin
         n_fail++;
         $display("FAIL wrap_grant1 got gnt=%b idx=%0d exp 0010/1", arb_if.gnt, arb_if.gnt_idx);
      end
   endtask

   task automatic test_drop_release();
      // Idx 1 is granted; a rel bit for another requester must be ignored.
      arb_if.rel = 4'b0001;
      tick();
      n_tests++;
      if (arb_if.gnt !== 4'b0010) begin
         n_fail++; $display("FAIL foreign_rel got %b exp 0010", arb_if.gnt);
      end
      arb_if.rel = 4'b0000;
      arb_if.req = 4'b0001;
      tick();
      n_tests++;
      if (arb_if.gnt !== 4'b0000 || arb_if.gnt_vld !== 1'b0) begin
         n_fail++;
         $display("FAIL drop_release got gnt=%b vld=%b exp 0000/0", arb_if.gnt, arb_if.gnt_vld);
      end
      n_tests++;
      if (arb_if.gnt_idx !== 2'd1) begin
         n_fail++; $display("FAIL idx_hold got %0d exp 1", arb_if.gnt_idx);
      end
      arb_if.req = 4'b0000;
      tick();
   endtask

   task automatic test_async_reset();
      arb_if.req = 4'b0100;
      tick();
      n_tests++;
      if (arb_if.gnt !== 4'b0100) begin
         n_fail++; $display("FAIL pre_reset_grant got %b exp 0100", arb_if.gnt);
      end
      #2;
      rst_n = 1'b0;
      #1;
      n_tests++;
      if (arb_if.gnt !== 4'b0000 || arb_if.gnt_vld !== 1'b0 || arb_if.gnt_idx !== 2'd0) begin
         n_fail++;
         $display("FAIL async_reset got gnt=%b vld=%b idx=%0d exp 0000/0/0",
                  arb_if.gnt, arb_if.gnt_vld, arb_if.gnt_idx);
      end
      arb_if.req = 4'b1111;
      tick();
      rst_n = 1'b1;
      tick();
      n_tests++;
      if (arb_if.gnt !== 4'b0001) begin
         n_fail++; $display("FAIL ptr_after_reset got %b exp 0001", arb_if.gnt);
      end
      arb_if.rel = 4'b0001;
      arb_if.req = 4'b0000;
      tick();
      arb_if.rel = 4'b0000;
      tick();
   endtask

`ifdef ARB_TIMEOUT_EN
   task automatic test_timeout();
      int held;
      held       = 0;
      arb_if.req = 4'b0001;
      tick();
      while (arb_if.gnt === 4'b0001 && held < 40) begin
         held++;
         n_tests++;
         if (arb_if.timeout !== 1'b0) begin
            n_fail++; $display("FAIL timeout_early cycle %0d got 1 exp 0", held);
         end
         tick();
      end
      n_tests++;
      if (held != 16) begin
         n_fail++; $display("FAIL hold_cycles got %0d exp 16", held);
      end
      n_tests++;
      if (arb_if.gnt !== 4'b0000 || arb_if.timeout !== 1'b1) begin
         n_fail++;
         $display("FAIL forced_release got gnt=%b timeout=%b exp 0000/1", arb_if.gnt, arb_if.timeout);
      end
      tick();
      n_tests++;
      if (arb_if.gnt !== 4'b0001 || arb_if.timeout !== 1'b0) begin
         n_fail++;
         $display("FAIL regrant got gnt=%b timeout=%b exp 0001/0", arb_if.gnt, arb_if.timeout);
      end
      // Fresh grant: hold=0 now; after 15 more cycles we are in grant cycle 16.
      for (int k = 0; k < 15; k++) tick();
      n_tests++;
      if (arb_if.gnt !== 4'b0001) begin
         n_fail++; $display("FAIL limit_cycle_gnt got %b exp 0001", arb_if.gnt);
      end
      arb_if.rel = 4'b0001;
      tick();
      arb_if.rel = 4'b0000;
      n_tests++;
      if (arb_if.gnt !== 4'b0000 || arb_if.timeout !== 1'b0) begin
         n_fail++;
         $display("FAIL rel_at_limit got gnt=%b timeout=%b exp 0000/0", arb_if.gnt, arb_if.timeout);
      end
      arb_if.req = 4'b0000;
      tick();
   endtask
`else
   task automatic test_no_timeout();
      int bad;
      bad        = 0;
      arb_if.req = 4'b0001;
      tick();
      for (int k = 0; k < 40; k++) begin
         if (arb_if.gnt !== 4'b0001 || arb_if.timeout !== 1'b0) bad++;
         tick();
      end
      n_tests++;
      if (bad != 0) begin
         n_fail++; $display("FAIL hold_forever got %0d bad cycles exp 0", bad);
      end
      arb_if.rel = 4'b0001;
      tick();
      arb_if.rel = 4'b0000;
      arb_if.req = 4'b0000;
      n_tests++;
      if (arb_if.gnt !== 4'b0000 || arb_if.timeout !== 1'b0) begin
         n_fail++;
         $display("FAIL late_release got gnt=%b timeout=%b exp 0000/0", arb_if.gnt, arb_if.timeout);
      end
      tick();
   endtask
`endif

   initial begin
      n_tests    = 0;
      n_fail     = 0;
      rst_n      = 1'b0;
      arb_if.req = 4'b0000;
      arb_if.rel = 4'b0000;
      test_reset();
      test_rotation();
      test_skip_wrap();
      test_drop_release();
      test_async_reset();
`ifdef ARB_TIMEOUT_EN
      test_timeout();
`else
      test_no_timeout();
`endif
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
